// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the multi-channel delay timer.
//   DEF_CNT_W / DEF_N_CH : default counter width and channel count
//   state_t              : per-channel state (ST_IDLE, ST_RUN)
//   MODE_*               : channel mode encodings sampled with set
package delay_timer_pkg;

  localparam int unsigned DEF_CNT_W = 17;
  localparam int unsigned DEF_N_CH  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/delay_timer_mc_if.sv
// Control/status bundle of the multi-channel delay timer.
//   set, abort, periodic [N_CH]  : per-channel strobes and mode (master -> slave)
//   value [N_CH*CNT_W]           : per-channel delay, channel i at [i*CNT_W +: CNT_W]
//   done, busy [N_CH]            : per-channel status (slave -> master)
//   remain [N_CH*CNT_W]          : clocks left per channel, only with DELAY_TIMER_REMAIN_EN
interface delay_timer_mc_if
  import delay_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned N_CH  = DEF_N_CH
);

  logic [N_CH-1:0]       set;
  logic [N_CH-1:0]       abort;
  logic [N_CH*CNT_W-1:0] value;
  logic [N_CH-1:0]       periodic;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       busy;
`ifdef DELAY_TIMER_REMAIN_EN
  logic [N_CH*CNT_W-1:0] remain;
`endif

  modport master (
    output set,
    output abort,
    output value,
    output periodic,
    input  done,
    input  busy
`ifdef DELAY_TIMER_REMAIN_EN
    ,
    input  remain
`endif
  );

  modport slave (
    input  set,
    input  abort,
    input  value,
    input  periodic,
    output done,
    output busy
`ifdef DELAY_TIMER_REMAIN_EN
    ,
    output remain
`endif
  );

endinterface

// File: rtl/delay_timer_ch.sv
// One delay-timer channel: latches a delay on set, pulses done after that many clocks,
// optionally auto-reloads. Abort beats set; set beats the terminal count.
//   clk, rst    : clock, asynchronous active-high reset
//   i_set       : start/restart strobe (samples i_value and i_periodic)
//   i_abort     : return to IDLE, suppressing any done this cycle
//   i_value     : delay in clocks (0 is treated as 1)
//   i_periodic  : mode sampled with i_set (MODE_ONESHOT / MODE_PERIODIC)
//   o_done      : registered one-clock terminal-count pulse
//   o_busy      : registered, high while in RUN
//   o_remain    : registered val_q - cnt in RUN, 0 in IDLE (DELAY_TIMER_REMAIN_EN only)
module delay_timer_ch
  import delay_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_periodic,
  output logic             o_done,
  output logic             o_busy
`ifdef DELAY_TIMER_REMAIN_EN
  ,
  output logic [CNT_W-1:0] o_remain
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_val;
  logic [CNT_W-1:0] w_val_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_term;

  // cnt never passes val_q, so equality is the terminal condition
  assign w_term = (r_cnt == r_val);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath; priority is abort > set > terminal count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (i_set) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = CNT_W'(1);
      w_val_nxt   = (i_value == '0) ? CNT_W'(1) : i_value;
      w_mode_nxt  = i_periodic;
    end else if (r_state == ST_RUN) begin
      if (w_term) begin
        w_done_nxt = 1'b1;
        if (r_mode == MODE_PERIODIC) begin
          w_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_val  <= '0;
      r_mode <= MODE_ONESHOT;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_val  <= w_val_nxt;
      r_mode <= w_mode_nxt;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign o_done = r_done;
  assign o_busy = r_busy;

`ifdef DELAY_TIMER_REMAIN_EN
  logic [CNT_W-1:0] r_remain;

  // Computed from next-state values so it tracks the registered cnt exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remain <= '0;
    end else begin
      r_remain <= (w_state_nxt == ST_RUN) ? (w_val_nxt - w_cnt_nxt) : '0;
    end
  end

  assign o_remain = r_remain;
`endif

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay timer: N_CH independent delay_timer_ch instances,
// with the top level only slicing the interface buses.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : delay_timer_mc_if slave (set/abort/value/periodic in, done/busy out)
// Optional feature: define DELAY_TIMER_REMAIN_EN to add the per-channel remain output.
module delay_timer_mc
  import delay_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned N_CH  = DEF_N_CH
) (
  input  logic            clk,
  input  logic            rst,
  delay_timer_mc_if.slave bus
);

  // One channel per bit / CNT_W-wide slice of the buses
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    delay_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_set      (bus.set[gi]),
      .i_abort    (bus.abort[gi]),
      .i_value    (bus.value[gi*CNT_W +: CNT_W]),
      .i_periodic (bus.periodic[gi]),
      .o_done     (bus.done[gi]),
      .o_busy     (bus.busy[gi])
`ifdef DELAY_TIMER_REMAIN_EN
      ,
      .o_remain   (bus.remain[gi*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Self-checking bench for delay_timer_mc: expected done pulses are queued per channel
// as absolute cycle numbers; a negedge monitor matches every observed pulse and flags
// missing or unexpected ones. Status outputs are checked directly at chosen cycles.
module tb_delay_timer_mc;
  import delay_timer_pkg::*;

  localparam int unsigned CNT_W = 17;
  localparam int unsigned N_CH  = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   exp_q [N_CH][$];

  delay_timer_mc_if #(.CNT_W(CNT_W), .N_CH(N_CH)) bus ();

  delay_timer_mc #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge E, cyc == E
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance one cycle and drop all strobes
  task automatic step();
    @(negedge clk);
    bus.set   = '0;
    bus.abort = '0;
  endtask

  // Drive a set for the next edge
  task automatic load(input int ch, input int val, input bit per);
    bus.value[ch*CNT_W +: CNT_W] = CNT_W'(val);
    bus.periodic[ch]             = per;
    bus.set[ch]                  = 1'b1;
  endtask

  // Expect a done pulse observed val clocks after the edge sampling a set driven now
  task automatic expect_done(input int ch, input int val);
    exp_q[ch].push_back(cyc + 1 + val);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int c = 0; c < int'(N_CH); c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL done%0d missing: expected at cycle %0d, no pulse by cycle %0d", c, exp_q[c][0], cyc);
        void'(exp_q[c].pop_front());
      end
      if (bus.done[c] === 1'b1) begin
        n_vec++;
        if (exp_q[c].size() == 0) begin
          n_err++;
          $display("FAIL done%0d unexpected pulse at cycle %0d, none expected", c, cyc);
        end else begin
          int e;
          e = exp_q[c].pop_front();
          if (e != cyc) begin
            n_err++;
            $display("FAIL done%0d timing: pulse at cycle %0d, expected at %0d", c, cyc, e);
          end
        end
      end
    end
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.set      = '0;
    bus.abort    = '0;
    bus.value    = '0;
    bus.periodic = '0;

    #1;
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
`ifdef DELAY_TIMER_REMAIN_EN
    chk("reset_remain", 32'(bus.remain[0 +: CNT_W]), 32'd0);
`endif
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: one-shot value 5
    load(0, 5, 1'b0);
    expect_done(0, 5);
    step();
    for (int j = 0; j < 5; j++) begin
      chk("t1_busy_run", 32'(bus.busy[0]), 32'd1);
      tick();
    end
    chk("t1_busy_end", 32'(bus.busy[0]), 32'd0);
    repeat (3) tick();

    // 2: periodic value 3, abort sampled at +7
    load(0, 3, 1'b1);
    expect_done(0, 3);
    expect_done(0, 6);
    step();
    chk("t2_busy_run", 32'(bus.busy[0]), 32'd1);
    repeat (6) tick();
    bus.abort[0] = 1'b1;
    step();
    chk("t2_busy_abort", 32'(bus.busy[0]), 32'd0);
    repeat (5) tick();

    // 3a: value 0 behaves as 1
    load(0, 0, 1'b0);
    expect_done(0, 1);
    step();
    chk("t3_v0_busy", 32'(bus.busy[0]), 32'd1);
    tick();
    chk("t3_v0_idle", 32'(bus.busy[0]), 32'd0);
    repeat (2) tick();

    // 3b: value 1 one-shot
    load(0, 1, 1'b0);
    expect_done(0, 1);
    step();
    tick();
    chk("t3_v1_idle", 32'(bus.busy[0]), 32'd0);
    repeat (2) tick();

    // 3c: periodic value 1 pulses every cycle until abort
    load(0, 1, 1'b1);
    for (int i = 1; i <= 5; i++) expect_done(0, i);
    step();
    repeat (5) tick();
    bus.abort[0] = 1'b1;
    step();
    chk("t3_per_abort", 32'(bus.busy[0]), 32'd0);
    repeat (3) tick();

    // 4: restart on the terminal edge of a value-4 run with value 6
    load(0, 4, 1'b0);
    expect_done(0, 10);
    step();
    repeat (3) tick();
    load(0, 6, 1'b0);
    step();
    chk("t4_busy_restart", 32'(bus.busy[0]), 32'd1);
    repeat (6) tick();
    chk("t4_busy_end", 32'(bus.busy[0]), 32'd0);
    repeat (3) tick();

    // 5a: set and abort together keeps the channel idle
    load(0, 5, 1'b0);
    bus.abort[0] = 1'b1;
    step();
    chk("t5_setabort_busy", 32'(bus.busy[0]), 32'd0);
    repeat (7) tick();

    // 5b: asynchronous reset mid-run of value 8
    load(0, 8, 1'b0);
    step();
    repeat (2) tick();
    chk("t5_busy_prerst", 32'(bus.busy[0]), 32'd1);
`ifdef DELAY_TIMER_REMAIN_EN
    chk("t5_remain_prerst", 32'(bus.remain[0 +: CNT_W]), 32'd5);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
`ifdef DELAY_TIMER_REMAIN_EN
    chk("t5_rst_remain", 32'(bus.remain[0 +: CNT_W]), 32'd0);
`endif
    tick();
    rst = 1'b0;
    repeat (10) tick();

    // 6: two channels in parallel, values 7 and 2
    load(0, 7, 1'b0);
    load(1, 2, 1'b0);
    expect_done(0, 7);
    expect_done(1, 2);
    step();
    for (int j = 0; j < 8; j++) begin
      chk("t6_busy0", 32'(bus.busy[0]), (j < 7) ? 32'd1 : 32'd0);
      chk("t6_busy1", 32'(bus.busy[1]), (j < 2) ? 32'd1 : 32'd0);
`ifdef DELAY_TIMER_REMAIN_EN
      chk("t6_remain0", 32'(bus.remain[0 +: CNT_W]), (j < 7) ? 32'(6 - j) : 32'd0);
`endif
      tick();
    end
    repeat (4) tick();

    // Anything still queued was never seen
    for (int c = 0; c < int'(N_CH); c++) begin
      while (exp_q[c].size() > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done%0d missing at end: expected at cycle %0d", c, exp_q[c][0]);
        void'(exp_q[c].pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
